// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Runtime-programmable UART oversample / bit tick generator.
//
// A divider counter runs 0..P-1 and raises o_tick for the single cycle where
// it holds P-1. P is the active integer divisor div_act. With the fractional
// option enabled, P is div_act+1 for the period that follows a carry out of
// the fractional accumulator. Every o_tick advances o_sample_idx. o_bit_tick
// marks the o_tick that closes a bit, which is the last oversample slot.
//
// A new divisor is written to a shadow register and waits there (pending)
// until the next period boundary or resync, so a running period is never cut
// short or stretched. o_div_ack pulses for one cycle after the new value
// becomes active.
//
// Optional feature macro: UART_BAUD_FRAC_EN (fractional divisor).
//
// Ports
//   i_clk         system clock, all logic on rising edge
//   i_reset       synchronous, active-high reset
//   i_enable      1 = count; 0 = freeze counter/index/accumulator, no ticks
//   i_resync      clear divider counter, sample index and accumulator
//   i_div_load    one-cycle strobe capturing i_div_int / i_div_frac
//   i_div_int     integer clocks per o_tick (values below 2 act as 2)
//   i_div_frac    fractional part in units of 2^-FRAC_BITS (feature only)
//   o_div_ack     one-cycle pulse: the newly loaded divisor is active
//   o_tick        one-cycle oversample tick
//   o_bit_tick    one-cycle pulse coincident with the last o_tick of a bit
//   o_sample_idx  index of the current oversample slot
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int unsigned CLK_FREQ_HZ  = 50000000,
   parameter int unsigned DEFAULT_BAUD = 19200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned DIV_WIDTH    = 16,
   parameter int unsigned FRAC_BITS    = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_resync,
   input  logic                          i_div_load,
   input  logic [DIV_WIDTH-1:0]          i_div_int,
   input  logic [FRAC_BITS-1:0]          i_div_frac,
   output logic                          o_div_ack,
   output logic                          o_tick,
   output logic                          o_bit_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] o_sample_idx
);

   localparam int unsigned IdxW = $clog2(OVERSAMPLE);
   // One spare bit so that div_act+1 never overflows the counter.
   localparam int unsigned CntW = DIV_WIDTH + 1;

   localparam logic [IdxW-1:0] IdxLast = IdxW'(OVERSAMPLE - 1);

   // Reset divisor derived from the clock and default baud rate.
   localparam longint unsigned TickRate = longint'(DEFAULT_BAUD) * longint'(OVERSAMPLE);
   localparam longint unsigned DivRaw   = longint'(CLK_FREQ_HZ) / TickRate;

   localparam logic [DIV_WIDTH-1:0] DivReset =
      (DivRaw < 64'd2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DivRaw);

   // Divisors below 2 would leave no room for a counter state besides the
   // tick state, so they are raised to 2.
   function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
      return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
   logic [DIV_WIDTH-1:0] div_shadow_q, div_shadow_d;
   logic                 pending_q, pending_d;
   logic                 ack_q, ack_d;

   // Set for the single period that takes one extra clock.
   logic                 extra;

   logic [CntW-1:0]      period;
   logic                 tick;
   logic                 apply;
   logic [DIV_WIDTH-1:0] div_next;

   // --------------------------------------------------------------------------
   // Fractional accumulator
   // --------------------------------------------------------------------------
`ifdef UART_BAUD_FRAC_EN
   localparam longint unsigned FracRaw =
      ((longint'(CLK_FREQ_HZ) - DivRaw * TickRate) << FRAC_BITS) / TickRate;
   localparam logic [FRAC_BITS-1:0] FracReset = FRAC_BITS'(FracRaw);

   logic [FRAC_BITS-1:0] frac_act_q, frac_act_d;
   logic [FRAC_BITS-1:0] frac_shadow_q, frac_shadow_d;
   logic [FRAC_BITS-1:0] frac_acc_q, frac_acc_d;
   logic                 extra_q, extra_d;
   logic [FRAC_BITS:0]   frac_sum;

   assign extra = extra_q;

   always_comb begin
      frac_act_d    = frac_act_q;
      frac_shadow_d = frac_shadow_q;
      frac_acc_d    = frac_acc_q;
      extra_d       = extra_q;
      frac_sum      = {1'b0, frac_acc_q} + {1'b0, frac_act_q};

      if (i_div_load) begin
         frac_shadow_d = i_div_frac;
      end
      if (apply) begin
         frac_act_d = i_div_load ? i_div_frac : frac_shadow_q;
      end

      if (i_resync) begin
         frac_acc_d = '0;
         extra_d    = 1'b0;
      end else if (tick) begin
         // The carry decides the length of the period that starts now.
         frac_acc_d = frac_sum[FRAC_BITS-1:0];
         extra_d    = frac_sum[FRAC_BITS];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         frac_act_q    <= FracReset;
         frac_shadow_q <= '0;
         frac_acc_q    <= '0;
         extra_q       <= 1'b0;
      end else begin
         frac_act_q    <= frac_act_d;
         frac_shadow_q <= frac_shadow_d;
         frac_acc_q    <= frac_acc_d;
         extra_q       <= extra_d;
      end
   end
`else
   logic unused_frac;

   assign extra       = 1'b0;
   assign unused_frac = ^i_div_frac;
`endif

   // --------------------------------------------------------------------------
   // Tick decode
   // --------------------------------------------------------------------------
   always_comb begin
      period = {1'b0, div_act_q} + CntW'(extra);
      tick   = !i_reset && i_enable && !i_resync && (cnt_q == (period - CntW'(1)));
   end

   // A waiting divisor (or one arriving this very cycle) takes over at a
   // period boundary or on resync, never mid-period.
   always_comb begin
      apply    = !i_reset && (tick || i_resync) && (pending_q || i_div_load);
      div_next = i_div_load ? clamp_div(i_div_int) : div_shadow_q;
   end

   // --------------------------------------------------------------------------
   // Next state
   // --------------------------------------------------------------------------
   always_comb begin
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      div_act_d    = div_act_q;
      div_shadow_d = div_shadow_q;
      pending_d    = pending_q;
      ack_d        = apply;

      if (i_div_load) begin
         div_shadow_d = clamp_div(i_div_int);
         pending_d    = 1'b1;
      end
      if (apply) begin
         div_act_d = div_next;
         pending_d = 1'b0;
      end

      if (i_resync) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (i_enable) begin
         if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         div_act_q    <= DivReset;
         div_shadow_q <= DivReset;
         pending_q    <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         div_act_q    <= div_act_d;
         div_shadow_q <= div_shadow_d;
         pending_q    <= pending_d;
         ack_q        <= ack_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      o_tick       = tick;
      o_bit_tick   = tick && (idx_q == IdxLast);
      o_sample_idx = idx_q;
      o_div_ack    = ack_q;
   end

endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;

   localparam int Timeout = 5000;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_resync;
   logic        i_div_load;
   logic [15:0] i_div_int;
   logic [3:0]  i_div_frac;
   logic        o_div_ack;
   logic        o_tick;
   logic        o_bit_tick;
   logic [3:0]  o_sample_idx;

   int checks = 0;
   int errors = 0;

   uart_baud_gen dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_resync     (i_resync),
      .i_div_load   (i_div_load),
      .i_div_int    (i_div_int),
      .i_div_frac   (i_div_frac),
      .o_div_ack    (o_div_ack),
      .o_tick       (o_tick),
      .o_bit_tick   (o_bit_tick),
      .o_sample_idx (o_sample_idx)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance falling edge by falling edge until o_tick is seen. n is the
   // number of edges advanced; a tick P cycles after the previous tick gives
   // n = P. acks counts o_div_ack pulses seen on the way.
   task automatic wait_tick(output int n, output int acks);
      n    = 0;
      acks = 0;
      do begin
         @(negedge i_clk);
         n++;
         if (o_div_ack) acks++;
      end while (!o_tick && n < Timeout);
   endtask

   int n;
   int acks;
   int ticks_seen;
   int sum;
   int n163;

   initial begin
      i_reset    = 1'b1;
      i_enable   = 1'b0;
      i_resync   = 1'b0;
      i_div_load = 1'b0;
      i_div_int  = '0;
      i_div_frac = '0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge i_clk);
      check("rst_tick", o_tick, 0);
      check("rst_bit_tick", o_bit_tick, 0);
      check("rst_idx", o_sample_idx, 0);
      check("rst_ack", o_div_ack, 0);

      i_reset  = 1'b0;
      i_enable = 1'b1;

      // Counter is 0 at this sample point, so the first tick (162nd cycle
      // counting this one) is 161 edges away.
      wait_tick(n, acks);
      check("t1_first_period", n, 161);
      check("t1_first_idx", o_sample_idx, 0);
      check("t1_first_bit", o_bit_tick, 0);

`ifdef UART_BAUD_FRAC_EN
      // 162 + 12/16: twelve periods of 163 and four of 162 per 16 ticks.
      sum  = 0;
      n163 = 0;
      for (int k = 0; k < 16; k++) begin
         wait_tick(n, acks);
         sum += n;
         if (n == 163) n163++;
      end
      check("t2_sum16", sum, 2604);
      check("t2_long_periods", n163, 12);
`else
      for (int k = 2; k <= 32; k++) begin
         wait_tick(n, acks);
         check("t1_period", n, 162);
         check("t1_idx", o_sample_idx, (k - 1) % 16);
         check("t1_bit_tick", o_bit_tick, (k % 16) == 0);
      end
`endif

      // ---------------- mid-period load ----------------
      i_resync = 1'b1;
      @(negedge i_clk);
      i_resync = 1'b0;
      check("t3_resync_idx", o_sample_idx, 0);
      repeat (50) @(negedge i_clk);
      i_div_load = 1'b1;
      i_div_int  = 16'd10;
      i_div_frac = 4'd0;
      @(negedge i_clk);
      i_div_load = 1'b0;
      wait_tick(n, acks);
      check("t3_old_period_end", n, 110);
      check("t3_no_early_ack", acks, 0);
      wait_tick(n, acks);
      check("t3_new_period", n, 10);
      check("t3_ack_once", acks, 1);
      wait_tick(n, acks);
      check("t3_new_period2", n, 10);
      check("t3_no_second_ack", acks, 0);

      // Two loads before the boundary: only the latest one lands.
      repeat (2) @(negedge i_clk);
      i_div_load = 1'b1;
      i_div_int  = 16'd20;
      @(negedge i_clk);
      i_div_int  = 16'd30;
      @(negedge i_clk);
      i_div_load = 1'b0;
      wait_tick(n, acks);
      check("t3_finish_10", n, 6);
      check("t3_finish_10_ack", acks, 0);
      wait_tick(n, acks);
      check("t3_latest_wins", n, 30);
      check("t3_latest_ack", acks, 1);
      wait_tick(n, acks);
      check("t3_latest_wins2", n, 30);
      check("t3_latest_noack", acks, 0);

      // Load coinciding with the boundary is applied directly.
      i_div_load = 1'b1;
      i_div_int  = 16'd25;
      @(negedge i_clk);
      i_div_load = 1'b0;
      check("t3_coincident_ack", o_div_ack, 1);
      wait_tick(n, acks);
      check("t3_coincident_period", n, 24);

      // ---------------- divisor clamp ----------------
      @(negedge i_clk);
      i_div_load = 1'b1;
      i_div_int  = 16'd1;
      @(negedge i_clk);
      i_div_load = 1'b0;
      wait_tick(n, acks);
      check("t4_finish_25", n, 23);
      wait_tick(n, acks);
      check("t4_div1_period", n, 2);
      check("t4_div1_ack", acks, 1);
      wait_tick(n, acks);
      check("t4_div1_period2", n, 2);

      @(negedge i_clk);
      i_div_load = 1'b1;
      i_div_int  = 16'd0;
      @(negedge i_clk);
      i_div_load = 1'b0;
      wait_tick(n, acks);
      check("t4_div0_period", n, 2);
      check("t4_div0_ack", acks, 1);
      wait_tick(n, acks);
      check("t4_div0_period2", n, 2);

      // ---------------- enable freeze, resync ----------------
      i_resync   = 1'b1;
      i_div_load = 1'b1;
      i_div_int  = 16'd162;
      i_div_frac = 4'd0;
      @(negedge i_clk);
      i_resync   = 1'b0;
      i_div_load = 1'b0;
      check("t5_resync_load_ack", o_div_ack, 1);
      check("t5_resync_idx", o_sample_idx, 0);
      repeat (100) @(negedge i_clk);
      i_enable   = 1'b0;
      ticks_seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge i_clk);
         if (o_tick || o_bit_tick) ticks_seen++;
      end
      check("t5_no_tick_disabled", ticks_seen, 0);
      i_enable = 1'b1;
      wait_tick(n, acks);
      check("t5_resume_at_101", n, 61);
      check("t5_resume_idx", o_sample_idx, 0);
      for (int k = 2; k <= 7; k++) begin
         wait_tick(n, acks);
         check("t5_period", n, 162);
      end
      check("t5_idx6_at_tick", o_sample_idx, 6);
      repeat (20) @(negedge i_clk);
      check("t5_idx7", o_sample_idx, 7);
      i_resync = 1'b1;
      @(negedge i_clk);
      i_resync = 1'b0;
      check("t5_resync_idx0", o_sample_idx, 0);
      wait_tick(n, acks);
      check("t5_after_resync", n, 161);
      check("t5_after_resync_idx", o_sample_idx, 0);

      // ---------------- reset with pending load ----------------
      repeat (5) @(negedge i_clk);
      i_div_load = 1'b1;
      i_div_int  = 16'd10;
      @(negedge i_clk);
      i_div_load = 1'b0;
      i_reset    = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      check("t6_tick", o_tick, 0);
      check("t6_bit_tick", o_bit_tick, 0);
      check("t6_idx", o_sample_idx, 0);
      check("t6_ack", o_div_ack, 0);
      wait_tick(n, acks);
      check("t6_first_period", n, 161);
      check("t6_no_ack", acks, 0);
      wait_tick(n, acks);
      check("t6_default_div", n, 162);
      check("t6_no_ack2", acks, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
